// File: rtl/boton_debounce.sv
// Push-button debouncer: a stable-sample counter FSM yields a clean level,
// single-cycle press/release strobes and a wrapping count of accepted presses.
module boton_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_in,
    input  logic               count_clr,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // press_pulse and release_pulse are plain one-cycle strobes with no
    // backpressure; a consumer must sample them in the cycle they are high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Clear takes effect first, then the pending press is counted on top.
    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = press_q ? COUNT_ONE : '0;
        end else if (press_q) begin
            count_d = count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_boton_debounce.sv
// Bench for boton_debounce: per-cycle scoreboard fed by a behavioural
// run-length model, plus hand-computed checkpoints for each scenario.
module tb_boton_debounce;

    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          sync_in;
    logic          count_clr;
    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic [CW-1:0] press_count;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    // {btn_level, press_pulse, release_pulse, press_count}
    logic [CW+2:0] exp_q[$];

    // Behavioural model: run length of samples differing from the level.
    logic          m_lvl = 1'b0;
    logic          m_pp  = 1'b0;
    logic          m_rp  = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    int            m_run = 0;

    boton_debounce #(
        .DEBOUNCE_CYCLES(D),
        .COUNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_in      (sync_in),
        .count_clr    (count_clr),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_count  (press_count),
        .dbg_state_o  (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply inputs for the next edge and push the outputs expected after it.
    task automatic drive(input logic s, input logic clr, input logic rn);
        logic          pp_n;
        logic          rp_n;
        logic [CW-1:0] cnt_n;
        sync_in   = s;
        count_clr = clr;
        rst_n     = rn;
        if (!rn) begin
            m_lvl = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_cnt = '0; m_run = 0;
        end else begin
            pp_n  = 1'b0;
            rp_n  = 1'b0;
            cnt_n = clr ? (m_pp ? CW'(1) : '0) : (m_pp ? m_cnt + CW'(1) : m_cnt);
            if (s != m_lvl) begin
                m_run++;
                if (m_run == D) begin
                    m_lvl = s;
                    m_run = 0;
                    pp_n  = s;
                    rp_n  = ~s;
                end
            end else begin
                m_run = 0;
            end
            m_pp  = pp_n;
            m_rp  = rp_n;
            m_cnt = cnt_n;
        end
        exp_q.push_back({m_lvl, m_pp, m_rp, m_cnt});
    endtask

    task automatic step(input logic s, input logic clr, input logic rn);
        drive(s, clr, rn);
        @(negedge clk);
    endtask

    task automatic repeat_step(input logic s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        logic [CW+2:0] e;
        logic [CW+2:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {btn_level, press_pulse, release_pulse, press_count};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs: got lvl=%b pp=%b rp=%b cnt=%0d expected lvl=%b pp=%b rp=%b cnt=%0d at %0t",
                             got[CW+2], got[CW+1], got[CW], got[CW-1:0],
                             e[CW+2], e[CW+1], e[CW], e[CW-1:0], $time);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        sync_in   = 1'b0;
        count_clr = 1'b0;
        @(negedge clk);

        // Reset
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("reset_level", 8'(btn_level), 8'd0);
        check("reset_pulses", 8'({press_pulse, release_pulse}), 8'd0);
        check("reset_count", 8'(press_count), 8'd0);

        // Bounce rejection: 1,1,1,0 never reaches four in a row
        for (int r = 0; r < 5; r++) begin
            repeat_step(1'b1, 3);
            step(1'b0, 1'b0, 1'b1);
            repeat_step(1'b1, 3);
            step(1'b0, 1'b0, 1'b1);
        end
        check("bounce_level", 8'(btn_level), 8'd0);
        check("bounce_count", 8'(press_count), 8'd0);

        // Clean press
        repeat_step(1'b1, 3);
        check("press_not_early", 8'(btn_level), 8'd0);
        step(1'b1, 1'b0, 1'b1);
        check("press_level", 8'(btn_level), 8'd1);
        check("press_pulse_on", 8'(press_pulse), 8'd1);
        step(1'b1, 1'b0, 1'b1);
        check("press_pulse_off", 8'(press_pulse), 8'd0);
        check("press_count_1", 8'(press_count), 8'd1);
        repeat_step(1'b1, 10);
        check("hold_count", 8'(press_count), 8'd1);

        // Release with a short bounce back to 1
        repeat_step(1'b0, 2);
        step(1'b1, 1'b0, 1'b1);
        repeat_step(1'b0, 3);
        check("release_not_early", 8'(btn_level), 8'd1);
        step(1'b0, 1'b0, 1'b1);
        check("release_level", 8'(btn_level), 8'd0);
        check("release_pulse_on", 8'(release_pulse), 8'd1);
        check("release_no_press", 8'(press_pulse), 8'd0);
        step(1'b0, 1'b0, 1'b1);
        check("release_count_kept", 8'(press_count), 8'd1);

        // Wrap: clear, then eight presses take the count 0..7 and back to 0
        step(1'b0, 1'b1, 1'b1);
        check("clear_count", 8'(press_count), 8'd0);
        for (int p = 1; p <= 8; p++) begin
            repeat_step(1'b1, 5);
            if (p == 7) check("wrap_count_7", 8'(press_count), 8'd7);
            if (p == 8) check("wrap_count_0", 8'(press_count), 8'd0);
            repeat_step(1'b0, 5);
        end

        // Clear coinciding with the press pulse still counts the press
        repeat_step(1'b1, 4);
        check("clr_press_pulse", 8'(press_pulse), 8'd1);
        step(1'b1, 1'b1, 1'b1);
        check("clr_with_press", 8'(press_count), 8'd1);
        step(1'b1, 1'b1, 1'b1);
        check("clr_alone", 8'(press_count), 8'd0);
        repeat_step(1'b0, 5);

        // Reset mid-debounce
        repeat_step(1'b1, 3);
        step(1'b1, 1'b0, 1'b0);
        check("midrst_no_pulse", 8'({press_pulse, release_pulse}), 8'd0);
        repeat_step(1'b1, 3);
        check("midrst_not_early", 8'(btn_level), 8'd0);
        step(1'b1, 1'b0, 1'b1);
        check("midrst_level", 8'(btn_level), 8'd1);
        check("midrst_pulse", 8'(press_pulse), 8'd1);
        step(1'b1, 1'b0, 1'b1);
        check("midrst_count", 8'(press_count), 8'd1);

        // Reset dropped between edges: nothing moves until the next edge
        drive(1'b1, 1'b0, 1'b0);
        #2;
        check("sync_rst_hold_level", 8'(btn_level), 8'd1);
        check("sync_rst_hold_count", 8'(press_count), 8'd1);
        @(negedge clk);
        check("sync_rst_level", 8'(btn_level), 8'd0);
        check("sync_rst_count", 8'(press_count), 8'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
